uart_paddle_cmd_decoder: RTL
============================

// Module: uart_paddle_cmd_decoder
// PURPOSE
//  Turns received UART command bytes into the level-held paddle_up/paddle_down/start
//  controls consumed by pong_controller (one instance per player).
//  - Sits between the UART receiver and the two paddle controllers.
//  - Stretches each single-byte keypress into a HOLD_CYCLES-long level.
//  - Runs a small game-state FSM (IDLE/RUN/PAUSE) that drives start.
// PARAMETERS
//  HOLD_CYCLES  6_000_000  cycles a direction stays asserted per keypress; must be > paddle DELAY+1
//  TMR_W        $clog2(HOLD_CYCLES)  hold-timer width (derived, not overridden)
// PORTS
//  clk         in   1  system clock (100 MHz); single clock domain
//  reset       in   1  synchronous, active-high reset
//  rx_data     in   8  received byte, valid when rx_valid=1
//  rx_valid    in   1  one byte per cycle in which it is high
//  p1_up       out  1  player-1 paddle up level
//  p1_down     out  1  player-1 paddle down level
//  p2_up       out  1  player-2 paddle up level
//  p2_down     out  1  player-2 paddle down level
//  start       out  1  high while game state = RUN
//  bad_cmd     out  1  1-cycle pulse: unrecognised byte received
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, both direction regs NONE, timers 0.
//    Reset mid-hold clears all outputs on the next cycle.
//  - All outputs are registered. A byte sampled in cycle N affects outputs from N+1.
//  - Command decode (letters case-insensitive):
//      'w' = P1 up      's' = P1 down
//      'i' = P2 up      'k' = P2 down
//      0x20 (space) = start/pause      'r' = return to IDLE
//      0x0D, 0x0A = ignored, no bad_cmd
//      any other byte = bad_cmd pulse in N+1, no other effect
//  - FSM transitions:
//      IDLE  --space--> RUN
//      RUN   --space--> PAUSE
//      PAUSE --space--> RUN
//      any state --'r'--> IDLE
//    start = (state==RUN).
//  - Leaving RUN (space or 'r') clears both players' direction regs the same edge.
//  - Paddle bytes outside RUN are ignored silently (no bad_cmd).
//  - Per-player hold, dir in {NONE,UP,DOWN}:
//      On UP/DOWN cmd in RUN: dir<=cmd, timer<=HOLD_CYCLES-1.
//      up/down = dir==UP / dir==DOWN, so up and down are never both high.
//      Level lasts exactly HOLD_CYCLES cycles (N+1..N+HOLD_CYCLES).
//      While dir!=NONE, timer decrements; when timer==0, dir<=NONE.
//      Same-direction repeat reloads the timer (retrigger).
//      Opposite direction switches immediately (no gap cycle), timer reloaded.
//      Load in the cycle the timer expires: load wins, no drop-out cycle.
//  - Commands for P1 never touch P2 state and vice versa.
//  - rx_valid held for k cycles counts as k bytes.
// STRUCTURE
//  - Package pong_cmd_pkg:
//      typedef enum game_state_t {IDLE,RUN,PAUSE}
//      typedef enum paddle_dir_t {NONE,UP,DOWN}
//      localparams for ASCII codes (W,S,I,K,SPACE,R,CR,LF)
//  - Sub-module paddle_hold_timer (dir reg + down-counter; inputs cmd_up, cmd_down, clear),
//    instantiated twice, once per player.
//  - Top holds the byte decoder, FSM and bad_cmd register.
// TESTING (HOLD_CYCLES=8)
//  1. reset 3 cycles, no bytes -> all outputs 0; send 'w' in IDLE -> p1_up stays 0, bad_cmd 0.
//  2. space, then 'w' at cycle N -> start=1 from N-?; p1_up=1 cycles N+1..N+8 exactly, 0 at N+9.
//  3. RUN: 's' at N, 'S' at N+5 -> p1_down continuously high N+1..N+13 (retrigger, no gap).
//  4. RUN: 'i' at N, 'k' at N+3 -> p2_up high N+1..N+3, p2_down high N+4..N+11;
//     p1_* stay 0 throughout.
//  5. 0x41 ('A') at N -> bad_cmd=1 only at N+1; 0x0D -> bad_cmd stays 0.
//  6. RUN with p1_up active: space -> PAUSE, start=0 and p1_up=0 next cycle;
//     'r' -> IDLE; reset asserted mid-hold -> all 0 next cycle.

Source files
------------

// File: rtl/pong_cmd_pkg.sv
// Shared types and ASCII command codes for the UART paddle command decoder.
// The case-folding helper lets the top compare against lowercase codes only.
package pong_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } paddle_dir_t;

   localparam logic [7:0] ASCII_W     = 8'h77;
   localparam logic [7:0] ASCII_S     = 8'h73;
   localparam logic [7:0] ASCII_I     = 8'h69;
   localparam logic [7:0] ASCII_K     = 8'h6B;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_R     = 8'h72;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   function automatic logic [7:0] toLower(input logic [7:0] b);
      if ((b >= 8'h41) && (b <= 8'h5A)) begin
         return b | 8'h20;
      end
      return b;
   endfunction

endpackage

// File: rtl/paddle_hold_timer.sv
// One player's paddle direction register plus hold down-counter; a keypress
// holds its direction for HOLD_CYCLES cycles, retriggered by any new keypress.
module paddle_hold_timer
   import pong_cmd_pkg::*;
#(
   parameter int HOLD_CYCLES = 6_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_up,
   input  logic cmd_down,
   input  logic clear,
   output logic up,
   output logic down
);

   localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

   paddle_dir_t      dir_q, dir_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   // A load takes priority over expiry, so a keypress on the last hold cycle leaves no gap.
   always_comb begin
      dir_d = dir_q;
      tmr_d = tmr_q;
      if (clear) begin
         dir_d = NONE;
         tmr_d = '0;
      end else if (cmd_up) begin
         dir_d = UP;
         tmr_d = TMR_LOAD;
      end else if (cmd_down) begin
         dir_d = DOWN;
         tmr_d = TMR_LOAD;
      end else if (dir_q != NONE) begin
         if (tmr_q == '0) begin
            dir_d = NONE;
         end else begin
            tmr_d = tmr_q - TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q <= NONE;
         tmr_q <= '0;
      end else begin
         dir_q <= dir_d;
         tmr_q <= tmr_d;
      end
   end

   assign up   = (dir_q == UP);
   assign down = (dir_q == DOWN);

endmodule

// File: rtl/uart_paddle_cmd_decoder.sv
// Decodes UART command bytes into held paddle levels for two players and
// runs the IDLE/RUN/PAUSE game-state machine that drives start.
module uart_paddle_cmd_decoder
   import pong_cmd_pkg::*;
#(
   parameter int HOLD_CYCLES = 6_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       p1_up,
   output logic       p1_down,
   output logic       p2_up,
   output logic       p2_down,
   output logic       start,
   output logic       bad_cmd
);

   game_state_t state_q, state_d;
   logic        bad_cmd_q, bad_cmd_d;
   logic [7:0]  cmdByte;
   logic        p1UpCmd, p1DownCmd, p2UpCmd, p2DownCmd;
   logic        clearDirs;

   // Paddle bytes only count while running; leaving RUN drops both players' holds.
   always_comb begin
      cmdByte   = toLower(rx_data);
      state_d   = state_q;
      bad_cmd_d = 1'b0;
      p1UpCmd   = 1'b0;
      p1DownCmd = 1'b0;
      p2UpCmd   = 1'b0;
      p2DownCmd = 1'b0;
      clearDirs = 1'b0;
      if (rx_valid) begin
         case (cmdByte)
            ASCII_W: p1UpCmd   = (state_q == RUN);
            ASCII_S: p1DownCmd = (state_q == RUN);
            ASCII_I: p2UpCmd   = (state_q == RUN);
            ASCII_K: p2DownCmd = (state_q == RUN);
            ASCII_SPACE: begin
               if (state_q == RUN) begin
                  state_d   = PAUSE;
                  clearDirs = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            ASCII_R: begin
               state_d   = IDLE;
               clearDirs = (state_q == RUN);
            end
            ASCII_CR, ASCII_LF: ;
            default: bad_cmd_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bad_cmd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bad_cmd_q <= bad_cmd_d;
      end
   end

   assign start   = (state_q == RUN);
   assign bad_cmd = bad_cmd_q;

   paddle_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_p1_timer (
      .clk      (clk),
      .reset    (reset),
      .cmd_up   (p1UpCmd),
      .cmd_down (p1DownCmd),
      .clear    (clearDirs),
      .up       (p1_up),
      .down     (p1_down)
   );

   paddle_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_p2_timer (
      .clk      (clk),
      .reset    (reset),
      .cmd_up   (p2UpCmd),
      .cmd_down (p2DownCmd),
      .clear    (clearDirs),
      .up       (p2_up),
      .down     (p2_down)
   );

endmodule
